// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//
// Purpose:
//   Shared definitions for the multi-port register file: default parameter
//   values, legal parameter limits, the default-width data type, the encoding
//   of a per-register write winner and the priority function that picks it.
//
// Contents:
//   REG_W / REG_A / REG_NR / REG_NW : default data width, address width,
//                                     read-port and write-port counts
//   REG_*_MAX / REG_*_MIN           : legal parameter bounds
//   reg_data_t                      : register word at the default width
//   WIN_*                           : winner encoding returned by wr_winner()
//   wr_winner()                     : lowest-index write port wins, the LUT
//                                     load port only wins if no port hits
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam int REG_W  = 8;
    localparam int REG_A  = 2;
    localparam int REG_NR = 2;
    localparam int REG_NW = 1;

    localparam int REG_W_MAX  = 8;
    localparam int REG_A_MAX  = 4;
    localparam int REG_NR_MIN = 1;
    localparam int REG_NR_MAX = 4;
    localparam int REG_NW_MIN = 1;
    localparam int REG_NW_MAX = 2;

    typedef logic [REG_W-1:0] reg_data_t;

    // Winner encoding: port p is encoded as p+1 so that zero means "no write".
    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_PORT0 = 2'd1;
    localparam logic [1:0] WIN_PORT1 = 2'd2;
    localparam logic [1:0] WIN_LUT   = 2'd3;

    // port_hit is padded to the maximum port count; unused bits are tied low.
    function automatic logic [1:0] wr_winner(input logic [1:0] port_hit,
                                             input logic       lut_hit);
        logic [1:0] win;
        win = WIN_NONE;
        if (port_hit[0]) begin
            win = WIN_PORT0;
        end else if (port_hit[1]) begin
            win = WIN_PORT1;
        end else if (lut_hit) begin
            win = WIN_LUT;
        end
        return win;
    endfunction

endpackage

// File: rtl/reg_file_wr_arb.sv
// ---------------------------------------------------------------------------
// reg_file_wr_arb
//
// Purpose:
//   Write selection for one register (index REG_IDX). Looks at every write
//   port and the LUT load port, picks the winner by priority and presents the
//   winning enable and data. The same result feeds both the storage update
//   and the read bypass, so the two can never disagree.
//
// Ports:
//   write_en  in  NW     per-port write strobe
//   waddr     in  NW*A   write addresses, port p at [p*A +: A]
//   data_in   in  NW*W   write data, port p at [p*W +: W]
//   lut_en    in  1      LUT load strobe
//   lut_addr  in  A      LUT load address
//   lut_data  in  W      LUT load data
//   win_en    out 1      a write to this register wins this cycle
//   win_data  out W      data of the winning write (0 when none)
// ---------------------------------------------------------------------------
module reg_file_wr_arb
    import reg_file_pkg::*;
#(
    parameter int W       = REG_W,
    parameter int A       = REG_A,
    parameter int NW      = REG_NW,
    parameter int REG_IDX = 0,
    parameter int ZERO_R0 = 0
) (
    input  logic [NW-1:0]   write_en,
    input  logic [NW*A-1:0] waddr,
    input  logic [NW*W-1:0] data_in,
    input  logic            lut_en,
    input  logic [A-1:0]    lut_addr,
    input  logic [W-1:0]    lut_data,
    output logic            win_en,
    output logic [W-1:0]    win_data
);

    localparam logic [A-1:0] MY_ADDR = A'(REG_IDX);

    // A hard-wired zero register never accepts a write from any source.
    localparam bit DROP = (ZERO_R0 != 0) && (REG_IDX == 0);

    logic [1:0] port_hit;
    logic       lut_hit;
    logic [1:0] winner;

    // Decode which sources address this register and resolve priority.
    always_comb begin
        port_hit = '0;
        for (int p = 0; p < NW; p++) begin
            port_hit[p] = write_en[p] && (waddr[p*A +: A] == MY_ADDR);
        end
        lut_hit = lut_en && (lut_addr == MY_ADDR);
        winner  = wr_winner(port_hit, lut_hit);
    end

    // Steer the winner's data; enable is suppressed for a zero register.
    always_comb begin
        win_data = '0;
        if (winner == WIN_LUT) begin
            win_data = lut_data;
        end
        for (int p = 0; p < NW; p++) begin
            if (winner == 2'(p + 1)) begin
                win_data = data_in[p*W +: W];
            end
        end
        win_en = (winner != WIN_NONE) && !DROP;
    end

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//
// Purpose:
//   Parametrised multi-port register file with NR combinational read ports,
//   NW prioritised write ports plus a lowest-priority LUT load port, optional
//   write-to-read bypass, an independent jump register and a per-register
//   busy scoreboard for multi-cycle producers.
//
// Parameters:
//   W (1-8) data width, A (1-4) address width (depth 2**A), NR (1-4) read
//   ports, NW (1-2) write ports, BYPASS forwards same-cycle writes to reads,
//   ZERO_R0 makes r0 a constant zero.
//
// Ports:
//   Clk          in  1       clock, rising edge
//   Reset        in  1       asynchronous active-low reset, clears all state
//   WriteEn      in  NW      per-port write strobe
//   Waddr        in  NW*A    write addresses
//   DataIn       in  NW*W    write data
//   LutEn        in  1       LUT load strobe
//   LutAddr      in  A       LUT load address
//   LutData      in  W       LUT load data
//   Raddr        in  NR*A    read addresses
//   SetInst      in  1       forces read port 0 to address 0
//   DataOut      out NR*W    read data
//   RdReady      out NR      addressed register is not busy
//   JumpEn       in  1       load the jump register
//   JumpData     in  W       jump target
//   JumpReg      out W       jump register contents
//   ReserveEn    in  1       mark ReserveAddr busy
//   ReserveAddr  in  A       register to reserve
//   Busy         out 2**A    scoreboard bits
// ---------------------------------------------------------------------------
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int W       = REG_W,
    parameter int A       = REG_A,
    parameter int NR      = REG_NR,
    parameter int NW      = REG_NW,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NW-1:0]       WriteEn,
    input  logic [NW*A-1:0]     Waddr,
    input  logic [NW*W-1:0]     DataIn,
    input  logic                LutEn,
    input  logic [A-1:0]        LutAddr,
    input  logic [W-1:0]        LutData,
    input  logic [NR*A-1:0]     Raddr,
    input  logic                SetInst,
    output logic [NR*W-1:0]     DataOut,
    output logic [NR-1:0]       RdReady,
    input  logic                JumpEn,
    input  logic [W-1:0]        JumpData,
    output logic [W-1:0]        JumpReg,
    input  logic                ReserveEn,
    input  logic [A-1:0]        ReserveAddr,
    output logic [(1<<A)-1:0]   Busy
);

    localparam int DEPTH = 1 << A;

    // Refuse to build with parameters outside the supported range.
    generate
        if ((W < 1) || (W > REG_W_MAX) || (A < 1) || (A > REG_A_MAX) ||
            (NR < REG_NR_MIN) || (NR > REG_NR_MAX) ||
            (NW < REG_NW_MIN) || (NW > REG_NW_MAX)) begin : g_bad_params
            $error("reg_file_mp: parameter out of range");
        end
    endgenerate

    logic [DEPTH-1:0][W-1:0] regs_q;
    logic [DEPTH-1:0][W-1:0] regs_d;
    logic [W-1:0]            jump_q;
    logic [W-1:0]            jump_d;
    logic [DEPTH-1:0]        busy_q;
    logic [DEPTH-1:0]        busy_d;

    logic [DEPTH-1:0]        win_en;
    logic [DEPTH-1:0][W-1:0] win_data;
    logic [DEPTH-1:0]        reserve_hit;
    logic [NR-1:0][A-1:0]    ea;

    // One arbiter per register resolves which source, if any, writes it.
    genvar r;
    generate
        for (r = 0; r < DEPTH; r++) begin : g_arb
            reg_file_wr_arb #(
                .W       (W),
                .A       (A),
                .NW      (NW),
                .REG_IDX (r),
                .ZERO_R0 (ZERO_R0)
            ) u_arb (
                .write_en (WriteEn),
                .waddr    (Waddr),
                .data_in  (DataIn),
                .lut_en   (LutEn),
                .lut_addr (LutAddr),
                .lut_data (LutData),
                .win_en   (win_en[r]),
                .win_data (win_data[r])
            );
        end
    endgenerate

    // Reserve decode; a zero register can never hold an outstanding producer.
    always_comb begin
        reserve_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            reserve_hit[i] = ReserveEn && (ReserveAddr == A'(i)) &&
                             !((ZERO_R0 != 0) && (i == 0));
        end
    end

    // Next state for storage, jump register and scoreboard. A reserve in the
    // same cycle as a write names a newer producer, so it keeps Busy set while
    // the older producer's data is still stored.
    always_comb begin
        regs_d = regs_q;
        jump_d = jump_q;
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (win_en[i]) begin
                regs_d[i] = win_data[i];
            end
            if (reserve_hit[i]) begin
                busy_d[i] = 1'b1;
            end else if (win_en[i]) begin
                busy_d[i] = 1'b0;
            end
        end
        if (JumpEn) begin
            jump_d = JumpData;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            regs_q <= '0;
            jump_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            jump_q <= jump_d;
            busy_q <= busy_d;
        end
    end

    // Effective read addresses: SetInst redirects port 0 to r0.
    always_comb begin
        ea = '0;
        for (int k = 0; k < NR; k++) begin
            ea[k] = Raddr[k*A +: A];
            if ((k == 0) && SetInst) begin
                ea[k] = '0;
            end
        end
    end

    // Read muxes. With bypass a winning write is forwarded and also makes the
    // register ready, unless a reserve in the same cycle re-marks it busy.
    always_comb begin
        DataOut = '0;
        RdReady = '0;
        for (int k = 0; k < NR; k++) begin
            DataOut[k*W +: W] = regs_q[ea[k]];
            RdReady[k]        = ~busy_q[ea[k]];
            if ((BYPASS != 0) && win_en[ea[k]]) begin
                DataOut[k*W +: W] = win_data[ea[k]];
                if (!reserve_hit[ea[k]]) begin
                    RdReady[k] = 1'b1;
                end
            end
            if ((ZERO_R0 != 0) && (ea[k] == '0)) begin
                DataOut[k*W +: W] = '0;
                RdReady[k]        = 1'b1;
            end
        end
    end

    assign JumpReg = jump_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//
// Two register files driven from the same stimulus:
//   dut_a : NW=2, BYPASS=1, ZERO_R0=0
//   dut_b : NW=1, BYPASS=0, ZERO_R0=1  (uses write port 0 slices only)
// Read data is compared as the full 16-bit {port1, port0} word.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

    logic        clk;
    logic        reset_n;
    logic [1:0]  write_en;
    logic [3:0]  waddr;
    logic [15:0] data_in;
    logic        lut_en;
    logic [1:0]  lut_addr;
    logic [7:0]  lut_data;
    logic [3:0]  raddr;
    logic        set_inst;
    logic        jump_en;
    logic [7:0]  jump_data;
    logic        reserve_en;
    logic [1:0]  reserve_addr;

    logic [15:0] a_data_out;
    logic [1:0]  a_rd_ready;
    logic [7:0]  a_jump_reg;
    logic [3:0]  a_busy;
    logic [15:0] b_data_out;
    logic [1:0]  b_rd_ready;
    logic [7:0]  b_jump_reg;
    logic [3:0]  b_busy;

    int errors;
    int checks;

    reg_file_mp #(
        .W(8), .A(2), .NR(2), .NW(2), .BYPASS(1), .ZERO_R0(0)
    ) dut_a (
        .Clk         (clk),
        .Reset       (reset_n),
        .WriteEn     (write_en),
        .Waddr       (waddr),
        .DataIn      (data_in),
        .LutEn       (lut_en),
        .LutAddr     (lut_addr),
        .LutData     (lut_data),
        .Raddr       (raddr),
        .SetInst     (set_inst),
        .DataOut     (a_data_out),
        .RdReady     (a_rd_ready),
        .JumpEn      (jump_en),
        .JumpData    (jump_data),
        .JumpReg     (a_jump_reg),
        .ReserveEn   (reserve_en),
        .ReserveAddr (reserve_addr),
        .Busy        (a_busy)
    );

    reg_file_mp #(
        .W(8), .A(2), .NR(2), .NW(1), .BYPASS(0), .ZERO_R0(1)
    ) dut_b (
        .Clk         (clk),
        .Reset       (reset_n),
        .WriteEn     (write_en[0:0]),
        .Waddr       (waddr[1:0]),
        .DataIn      (data_in[7:0]),
        .LutEn       (lut_en),
        .LutAddr     (lut_addr),
        .LutData     (lut_data),
        .Raddr       (raddr),
        .SetInst     (set_inst),
        .DataOut     (b_data_out),
        .RdReady     (b_rd_ready),
        .JumpEn      (jump_en),
        .JumpData    (jump_data),
        .JumpReg     (b_jump_reg),
        .ReserveEn   (reserve_en),
        .ReserveAddr (reserve_addr),
        .Busy        (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still ends with a report.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [1:0]  we,
                                 input logic [3:0]  wa,
                                 input logic [15:0] di,
                                 input logic        le,
                                 input logic [1:0]  la,
                                 input logic [7:0]  ld,
                                 input logic [3:0]  ra,
                                 input logic        si,
                                 input logic        je,
                                 input logic [7:0]  jd,
                                 input logic        re,
                                 input logic [1:0]  rsa);
        write_en     = we;
        waddr        = wa;
        data_in      = di;
        lut_en       = le;
        lut_addr     = la;
        lut_data     = ld;
        raddr        = ra;
        set_inst     = si;
        jump_en      = je;
        jump_data    = jd;
        reserve_en   = re;
        reserve_addr = rsa;
    endtask

    task automatic idle(input logic [3:0] ra);
        applyStimulus(2'b00, 4'h0, 16'h0000, 1'b0, 2'd0, 8'h00, ra, 1'b0,
                      1'b0, 8'h00, 1'b0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string       tag,
                               input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        idle(4'h0);

        // Reset state
        #12;
        checkOutput("rst0_a_data",  a_data_out, 16'h0000);
        checkOutput("rst0_a_ready", {14'h0, a_rd_ready}, 16'h0003);
        checkOutput("rst0_a_busy",  {12'h0, a_busy}, 16'h0000);
        checkOutput("rst0_b_ready", {14'h0, b_rd_ready}, 16'h0003);
        @(negedge clk);
        reset_n = 1'b1;

        // Build some state, then reset mid-cycle
        applyStimulus(2'b01, 4'b0001, 16'h0055, 1'b0, 2'd0, 8'h00, 4'b0101,
                      1'b0, 1'b1, 8'h12, 1'b1, 2'd3);
        tick();
        idle(4'b0101);
        checkOutput("pre_rst_a_data", a_data_out, 16'h5555);
        checkOutput("pre_rst_b_data", b_data_out, 16'h5555);
        checkOutput("pre_rst_a_jump", {8'h0, a_jump_reg}, 16'h0012);
        checkOutput("pre_rst_a_busy", {12'h0, a_busy}, 16'h0008);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_a_data",  a_data_out, 16'h0000);
        checkOutput("rst_b_data",  b_data_out, 16'h0000);
        checkOutput("rst_a_jump",  {8'h0, a_jump_reg}, 16'h0000);
        checkOutput("rst_a_busy",  {12'h0, a_busy}, 16'h0000);
        checkOutput("rst_a_ready", {14'h0, a_rd_ready}, 16'h0003);
        @(negedge clk);
        reset_n = 1'b1;

        // Priority: port0 beats port1 and LUT on r2
        applyStimulus(2'b11, 4'b1010, 16'h2211, 1'b1, 2'd2, 8'h33, 4'b1000,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        #1;
        checkOutput("prio_a_bypass", a_data_out, 16'h1100);
        checkOutput("prio_b_nobyp",  b_data_out, 16'h0000);
        tick();
        idle(4'b1000);
        checkOutput("prio_a_r2", a_data_out, 16'h1100);
        checkOutput("prio_b_r2", b_data_out, 16'h1100);

        // LUT-only write to r3
        applyStimulus(2'b00, 4'b0000, 16'h0000, 1'b1, 2'd3, 8'h33, 4'b1100,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        #1;
        checkOutput("lut_a_bypass", a_data_out, 16'h3300);
        checkOutput("lut_b_nobyp",  b_data_out, 16'h0000);
        tick();
        idle(4'b1100);
        checkOutput("lut_a_r3", a_data_out, 16'h3300);
        checkOutput("lut_b_r3", b_data_out, 16'h3300);

        // Bypass vs. one-cycle latency on r1
        applyStimulus(2'b01, 4'b0001, 16'h00A5, 1'b0, 2'd0, 8'h00, 4'b0100,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        #1;
        checkOutput("byp_a_same", a_data_out, 16'hA500);
        checkOutput("byp_b_same", b_data_out, 16'h0000);
        tick();
        idle(4'b0100);
        checkOutput("byp_b_next", b_data_out, 16'hA500);

        // SetInst: r0=0x07, r3=0x09
        applyStimulus(2'b01, 4'b0000, 16'h0007, 1'b0, 2'd0, 8'h00, 4'b0000,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        applyStimulus(2'b01, 4'b0011, 16'h0009, 1'b0, 2'd0, 8'h00, 4'b0000,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        applyStimulus(2'b00, 4'b0000, 16'h0000, 1'b0, 2'd0, 8'h00, 4'b0011,
                      1'b1, 1'b0, 8'h00, 1'b0, 2'd0);
        #1;
        checkOutput("setinst_a", a_data_out, 16'h0707);
        checkOutput("setinst_b", b_data_out, 16'h0000);
        set_inst = 1'b0;
        #1;
        checkOutput("nosetinst_a", a_data_out, 16'h0709);
        checkOutput("nosetinst_b", b_data_out, 16'h0009);

        // Write 0xFF to r0: dropped on the zero-r0 file only
        applyStimulus(2'b01, 4'b0000, 16'h00FF, 1'b0, 2'd0, 8'h00, 4'b0000,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        #1;
        checkOutput("r0w_a_bypass", a_data_out, 16'hFFFF);
        tick();
        idle(4'b0000);
        checkOutput("r0w_a_next",  a_data_out, 16'hFFFF);
        checkOutput("r0w_b_next",  b_data_out, 16'h0000);
        checkOutput("r0w_b_ready", {14'h0, b_rd_ready}, 16'h0003);

        // Scoreboard: reserve r2, write two cycles later
        applyStimulus(2'b00, 4'b0000, 16'h0000, 1'b0, 2'd0, 8'h00, 4'b1000,
                      1'b0, 1'b0, 8'h00, 1'b1, 2'd2);
        tick();
        idle(4'b1000);
        checkOutput("rsv_a_busy",  {12'h0, a_busy}, 16'h0004);
        checkOutput("rsv_a_ready", {14'h0, a_rd_ready}, 16'h0001);
        checkOutput("rsv_b_busy",  {12'h0, b_busy}, 16'h0004);
        tick();
        applyStimulus(2'b01, 4'b0010, 16'h005A, 1'b0, 2'd0, 8'h00, 4'b1000,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        #1;
        checkOutput("wb_a_ready_byp", {14'h0, a_rd_ready}, 16'h0003);
        checkOutput("wb_b_ready_nob", {14'h0, b_rd_ready}, 16'h0001);
        checkOutput("wb_a_data_byp",  a_data_out, 16'h5AFF);
        tick();
        idle(4'b1000);
        checkOutput("wb_a_busy", {12'h0, a_busy}, 16'h0000);
        checkOutput("wb_b_busy", {12'h0, b_busy}, 16'h0000);

        // Same-cycle reserve and write to r2
        applyStimulus(2'b01, 4'b0010, 16'h006B, 1'b0, 2'd0, 8'h00, 4'b1000,
                      1'b0, 1'b0, 8'h00, 1'b1, 2'd2);
        tick();
        idle(4'b1000);
        checkOutput("rsvwr_a_busy", {12'h0, a_busy}, 16'h0004);
        checkOutput("rsvwr_a_data", a_data_out, 16'h6BFF);
        checkOutput("rsvwr_b_busy", {12'h0, b_busy}, 16'h0004);
        checkOutput("rsvwr_b_data", b_data_out, 16'h6B00);

        // Reserve r0: dropped on the zero-r0 file
        applyStimulus(2'b00, 4'b0000, 16'h0000, 1'b0, 2'd0, 8'h00, 4'b1000,
                      1'b0, 1'b0, 8'h00, 1'b1, 2'd0);
        tick();
        idle(4'b1000);
        checkOutput("rsv0_a_busy", {12'h0, a_busy}, 16'h0005);
        checkOutput("rsv0_b_busy", {12'h0, b_busy}, 16'h0004);

        // Reserve an already-busy register
        applyStimulus(2'b00, 4'b0000, 16'h0000, 1'b0, 2'd0, 8'h00, 4'b1000,
                      1'b0, 1'b0, 8'h00, 1'b1, 2'd2);
        tick();
        idle(4'b1000);
        checkOutput("rsvbusy_a_busy", {12'h0, a_busy}, 16'h0005);

        // Jump register alongside a GPR write
        applyStimulus(2'b01, 4'b0001, 16'h0044, 1'b0, 2'd0, 8'h00, 4'b0100,
                      1'b0, 1'b1, 8'h3C, 1'b0, 2'd0);
        tick();
        idle(4'b0100);
        checkOutput("jump_a_reg",  {8'h0, a_jump_reg}, 16'h003C);
        checkOutput("jump_b_reg",  {8'h0, b_jump_reg}, 16'h003C);
        checkOutput("jump_a_data", a_data_out, 16'h44FF);
        checkOutput("jump_b_data", b_data_out, 16'h4400);

        // Reset with outstanding producers, then a late writeback
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rstbusy_a", {12'h0, a_busy}, 16'h0000);
        checkOutput("rstbusy_b", {12'h0, b_busy}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(2'b01, 4'b0010, 16'h0077, 1'b0, 2'd0, 8'h00, 4'b1000,
                      1'b0, 1'b0, 8'h00, 1'b0, 2'd0);
        tick();
        idle(4'b1000);
        checkOutput("late_a_data", a_data_out, 16'h7700);
        checkOutput("late_b_data", b_data_out, 16'h7700);
        checkOutput("late_a_busy", {12'h0, a_busy}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
